// File: rtl/stage3_sdf_butterfly.sv
// Stage-3 radix-2 DIF single-path delay-feedback butterfly.
// Delay line of 8 complex samples, frame of 16; drives the stage-3 twiddle
// ROM and multiplies the selected operand by the returned Q1.12 twiddle.
module stage3_sdf_butterfly #(
    parameter int DW = 16,
    parameter int TW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    output logic [2:0]           rom_addr,
    input  logic [2*TW-1:0]      rom_dout,
    output logic                 dout_valid,
    output logic signed [DW-1:0] dout_re,
    output logic signed [DW-1:0] dout_im
);

    localparam int PW   = DW + TW;
    localparam int FRAC = 12;
    localparam logic signed [TW-1:0] TW_ONE = TW'(4096);

    logic [3:0]           cnt;
    logic                 primed;
    logic signed [DW-1:0] fifo_re [8];
    logic signed [DW-1:0] fifo_im [8];

    logic signed [DW-1:0] f_re, f_im;
    logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
    logic signed [DW-1:0] push_re, push_im, opnd_re, opnd_im;

    logic                 s1_valid, s1_half;
    logic signed [DW-1:0] s1_re, s1_im;
    logic                 s2_valid, s2_half;
    logic signed [DW-1:0] s2_re, s2_im;
    logic signed [TW-1:0] tw_re, tw_im;
    logic                 s3_valid;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]   acc_re, acc_im;

    // Drop the Q1.12 fraction and clamp to the DW-bit output range.
    function automatic logic signed [DW-1:0] sat(input logic signed [PW:0] v);
        logic signed [PW:0] sh;
        sh = v >>> FRAC;
        if ((&sh[PW:DW-1]) || !(|sh[PW:DW-1]))
            return DW'(sh);
        else if (sh[PW])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign f_re = fifo_re[7];
    assign f_im = fifo_im[7];

    // Butterfly: first half stores the input and forwards the stored difference,
    // second half stores the halved difference and forwards the halved sum.
    always_comb begin
        sum_re  = {f_re[DW-1], f_re} + {din_re[DW-1], din_re};
        sum_im  = {f_im[DW-1], f_im} + {din_im[DW-1], din_im};
        dif_re  = {f_re[DW-1], f_re} - {din_re[DW-1], din_re};
        dif_im  = {f_im[DW-1], f_im} - {din_im[DW-1], din_im};
        push_re = din_re;
        push_im = din_im;
        opnd_re = f_re;
        opnd_im = f_im;
        if (cnt[3]) begin
            push_re = DW'(dif_re >>> 1);
            push_im = DW'(dif_im >>> 1);
            opnd_re = DW'(sum_re >>> 1);
            opnd_im = DW'(sum_im >>> 1);
        end
    end

    // Sample counter, priming flag, delay line and ROM address advance only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            primed   <= 1'b0;
            rom_addr <= '0;
            for (int i = 0; i < 8; i++) begin
                fifo_re[i] <= '0;
                fifo_im[i] <= '0;
            end
        end else if (din_valid) begin
            cnt      <= cnt + 4'd1;
            rom_addr <= cnt[2:0];
            if (cnt == 4'd7)
                primed <= 1'b1;
            fifo_re[0] <= push_re;
            fifo_im[0] <= push_im;
            for (int i = 1; i < 8; i++) begin
                fifo_re[i] <= fifo_re[i-1];
                fifo_im[i] <= fifo_im[i-1];
            end
        end
    end

    // Capture the operand; priming is folded into the valid bit here.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_half  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= din_valid & primed;
            s1_half  <= cnt[3];
            s1_re    <= opnd_re;
            s1_im    <= opnd_im;
        end
    end

    // Delay the operand one cycle so it meets the registered ROM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_half  <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_half  <= s1_half;
            s2_re    <= s1_re;
            s2_im    <= s1_im;
        end
    end

    // Second-half samples bypass the ROM with a unity twiddle.
    always_comb begin
        tw_re = rom_dout[2*TW-1:TW];
        tw_im = rom_dout[TW-1:0];
        if (s2_half) begin
            tw_re = TW_ONE;
            tw_im = '0;
        end
    end

    // Register the four partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else begin
            s3_valid <= s2_valid;
            p_rr     <= PW'(s2_re) * PW'(tw_re);
            p_ii     <= PW'(s2_im) * PW'(tw_im);
            p_ri     <= PW'(s2_re) * PW'(tw_im);
            p_ir     <= PW'(s2_im) * PW'(tw_re);
        end
    end

    // Combine products at full width before scaling.
    always_comb begin
        acc_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        acc_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    end

    // Output register holds the last valid result between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            dout_valid <= s3_valid;
            if (s3_valid) begin
                dout_re <= sat(acc_re);
                dout_im <= sat(acc_im);
            end
        end
    end

endmodule

// File: tb/tb_stage3_sdf_butterfly.sv
// Directed self-checking bench for stage3_sdf_butterfly with a registered
// twiddle ROM model (W^k = cos - j sin of 2*pi*k/16 in Q1.12).
module tb_stage3_sdf_butterfly;

    localparam int DW = 16;
    localparam int TW = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 din_valid;
    logic signed [DW-1:0] din_re, din_im;
    logic [2:0]           rom_addr;
    logic [2*TW-1:0]      rom_dout;
    logic                 dout_valid;
    logic signed [DW-1:0] dout_re, dout_im;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_re[$];
    int out_im[$];
    int out_cyc[$];
    int acc_cyc[$];

    stage3_sdf_butterfly #(.DW(DW), .TW(TW)) dut (
        .clk(clk),
        .rst(rst),
        .din_valid(din_valid),
        .din_re(din_re),
        .din_im(din_im),
        .rom_addr(rom_addr),
        .rom_dout(rom_dout),
        .dout_valid(dout_valid),
        .dout_re(dout_re),
        .dout_im(dout_im)
    );

    function automatic logic [2*TW-1:0] rom_val(input logic [2:0] a);
        logic signed [TW-1:0] wr, wi;
        case (a)
            3'd0:    begin wr =  14'sd4096; wi =  14'sd0;    end
            3'd1:    begin wr =  14'sd3784; wi = -14'sd1567; end
            3'd2:    begin wr =  14'sd2896; wi = -14'sd2896; end
            3'd3:    begin wr =  14'sd1567; wi = -14'sd3784; end
            3'd4:    begin wr =  14'sd0;    wi = -14'sd4096; end
            3'd5:    begin wr = -14'sd1567; wi = -14'sd3784; end
            3'd6:    begin wr = -14'sd2896; wi = -14'sd2896; end
            default: begin wr = -14'sd3784; wi = -14'sd1567; end
        endcase
        return {wr, wi};
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_dout <= rom_val(rom_addr);

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            out_re.push_back(int'(dout_re));
            out_im.push_back(int'(dout_im));
            out_cyc.push_back(cyc);
        end
    end

    task automatic send(input int re, input int im, input logic v);
        din_valid = v;
        din_re    = DW'(re);
        din_im    = DW'(im);
        @(negedge clk);
        if (v && !rst)
            acc_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 0, 1'b0);
    endtask

    task automatic clear_log;
        out_re.delete();
        out_im.delete();
        out_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        din_valid = 1'b1;
        din_re    = 16'sd123;
        din_im    = 16'sd45;
        repeat (2) @(negedge clk);
        checks++;
        if (rom_addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_rom_addr: got %0d, expected 0", rom_addr);
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dout_valid: got %0b, expected 0", dout_valid);
        end
        checks++;
        if (dout_re !== 16'sd0 || dout_im !== 16'sd0) begin
            errors++;
            $display("[TB] FAIL reset_dout: got %0d/%0d, expected 0/0", dout_re, dout_im);
        end
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) send(777, -5, 1'b1);
        checks++;
        if (rom_addr !== 3'd7) begin
            errors++;
            $display("[TB] FAIL prime_rom_addr: got %0d, expected 7", rom_addr);
        end
        idle(4);
        checks++;
        if (out_re.size() != 0) begin
            errors++;
            $display("[TB] FAIL prime_no_output: got %0d outputs, expected 0", out_re.size());
        end
        send(777, -5, 1'b1);
        idle(4);
        checks++;
        if (rom_addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL second_half_rom_addr: got %0d, expected 0", rom_addr);
        end
        checks++;
        if (out_re.size() != 1) begin
            errors++;
            $display("[TB] FAIL primed_output_count: got %0d, expected 1", out_re.size());
        end else begin
            checks++;
            if (out_re[0] != 777 || out_im[0] != -5) begin
                errors++;
                $display("[TB] FAIL primed_output: got %0d/%0d, expected 777/-5", out_re[0], out_im[0]);
            end
            checks++;
            if (out_cyc[0] - acc_cyc[8] != 3) begin
                errors++;
                $display("[TB] FAIL primed_latency: got %0d, expected 3", out_cyc[0] - acc_cyc[8]);
            end
        end
    endtask

    task automatic test_dc;
        int exp_re[24];
        for (int j = 0; j < 24; j++) exp_re[j] = (j < 8) ? 1000 : 0;
        do_reset(2);
        for (int i = 0; i < 32; i++) send((i < 16) ? 1000 : 0, 0, 1'b1);
        idle(5);
        checks++;
        if (out_re.size() != 24) begin
            errors++;
            $display("[TB] FAIL dc_count: got %0d, expected 24", out_re.size());
        end
        for (int j = 0; j < 24; j++) begin
            if (j < out_re.size()) begin
                checks++;
                if (out_re[j] != exp_re[j] || out_im[j] != 0) begin
                    errors++;
                    $display("[TB] FAIL dc_out[%0d]: got %0d/%0d, expected %0d/0", j + 8, out_re[j], out_im[j], exp_re[j]);
                end
                checks++;
                if (out_cyc[j] - acc_cyc[j+8] != 3) begin
                    errors++;
                    $display("[TB] FAIL dc_latency[%0d]: got %0d, expected 3", j + 8, out_cyc[j] - acc_cyc[j+8]);
                end
            end
        end
    endtask

    task automatic test_impulse;
        int exp_re[24];
        for (int j = 0; j < 24; j++) exp_re[j] = (j == 0 || j == 8) ? 500 : 0;
        do_reset(2);
        for (int i = 0; i < 32; i++) send((i == 0) ? 1000 : 0, 0, 1'b1);
        idle(5);
        checks++;
        if (out_re.size() != 24) begin
            errors++;
            $display("[TB] FAIL impulse_count: got %0d, expected 24", out_re.size());
        end
        for (int j = 0; j < 24; j++) begin
            if (j < out_re.size()) begin
                checks++;
                if (out_re[j] != exp_re[j] || out_im[j] != 0) begin
                    errors++;
                    $display("[TB] FAIL impulse_out[%0d]: got %0d/%0d, expected %0d/0", j + 8, out_re[j], out_im[j], exp_re[j]);
                end
            end
        end
    endtask

    task automatic test_saturation;
        int exp_re[24];
        int exp_im[24];
        for (int j = 0; j < 24; j++) begin
            exp_re[j] = 0;
            exp_im[j] = 0;
        end
        exp_re[2]  = -1;
        exp_im[2]  = -1;
        exp_re[10] = 32767;
        exp_im[10] = 0;
        do_reset(2);
        for (int i = 0; i < 32; i++) begin
            if (i == 2)
                send(32767, 32767, 1'b1);
            else if (i == 10)
                send(-32768, -32768, 1'b1);
            else
                send(0, 0, 1'b1);
        end
        idle(5);
        checks++;
        if (out_re.size() != 24) begin
            errors++;
            $display("[TB] FAIL sat_count: got %0d, expected 24", out_re.size());
        end
        for (int j = 0; j < 24; j++) begin
            if (j < out_re.size()) begin
                checks++;
                if (out_re[j] != exp_re[j] || out_im[j] != exp_im[j]) begin
                    errors++;
                    $display("[TB] FAIL sat_out[%0d]: got %0d/%0d, expected %0d/%0d", j + 8, out_re[j], out_im[j], exp_re[j], exp_im[j]);
                end
            end
        end
    endtask

    task automatic test_gaps;
        int exp_re[24];
        for (int j = 0; j < 24; j++) exp_re[j] = (j == 0 || j == 8) ? 500 : 0;
        do_reset(2);
        for (int i = 0; i < 32; i++) begin
            send((i == 0) ? 1000 : 0, 0, 1'b1);
            send(0, 0, 1'b0);
        end
        idle(4);
        checks++;
        if (rom_addr !== 3'd7) begin
            errors++;
            $display("[TB] FAIL gaps_rom_addr: got %0d, expected 7", rom_addr);
        end
        checks++;
        if (out_re.size() != 24) begin
            errors++;
            $display("[TB] FAIL gaps_count: got %0d, expected 24", out_re.size());
        end
        for (int j = 0; j < 24; j++) begin
            if (j < out_re.size()) begin
                checks++;
                if (out_re[j] != exp_re[j] || out_im[j] != 0) begin
                    errors++;
                    $display("[TB] FAIL gaps_out[%0d]: got %0d/%0d, expected %0d/0", j + 8, out_re[j], out_im[j], exp_re[j]);
                end
                checks++;
                if (out_cyc[j] - acc_cyc[j+8] != 3) begin
                    errors++;
                    $display("[TB] FAIL gaps_latency[%0d]: got %0d, expected 3", j + 8, out_cyc[j] - acc_cyc[j+8]);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        int exp_re[10];
        for (int j = 0; j < 10; j++) exp_re[j] = (j == 0 || j == 8) ? 500 : 0;
        do_reset(2);
        for (int i = 0; i < 21; i++) send((i == 0) ? 1000 : 0, 0, 1'b1);
        rst = 1'b1;
        send(0, 0, 1'b1);
        rst = 1'b0;
        idle(5);
        checks++;
        if (out_re.size() != 10) begin
            errors++;
            $display("[TB] FAIL midrst_count: got %0d, expected 10", out_re.size());
        end
        for (int j = 0; j < 10; j++) begin
            if (j < out_re.size()) begin
                checks++;
                if (out_re[j] != exp_re[j] || out_im[j] != 0) begin
                    errors++;
                    $display("[TB] FAIL midrst_out[%0d]: got %0d/%0d, expected %0d/0", j + 8, out_re[j], out_im[j], exp_re[j]);
                end
            end
        end
        clear_log();
        for (int i = 0; i < 8; i++) send(1000, 0, 1'b1);
        idle(5);
        checks++;
        if (out_re.size() != 0) begin
            errors++;
            $display("[TB] FAIL midrst_reprime: got %0d outputs, expected 0", out_re.size());
        end
        send(0, 0, 1'b1);
        idle(4);
        checks++;
        if (out_re.size() != 1) begin
            errors++;
            $display("[TB] FAIL midrst_after_count: got %0d, expected 1", out_re.size());
        end else begin
            checks++;
            if (out_re[0] != 500 || out_im[0] != 0) begin
                errors++;
                $display("[TB] FAIL midrst_after_out: got %0d/%0d, expected 500/0", out_re[0], out_im[0]);
            end
            checks++;
            if (out_cyc[0] - acc_cyc[8] != 3) begin
                errors++;
                $display("[TB] FAIL midrst_after_latency: got %0d, expected 3", out_cyc[0] - acc_cyc[8]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din_re    = '0;
        din_im    = '0;
        @(negedge clk);
        test_reset();
        test_dc();
        test_impulse();
        test_saturation();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
